// File: rtl/cram_pkg.sv
// Shared CellularRAM definitions: bus widths, controller op codes, state encodings and
// the request bundle used by the port arbiter.
package cram_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    typedef logic [2:0] ramOp_t;

    localparam ramOp_t OP_NULL        = 3'd0;
    localparam ramOp_t OP_ASYNC_READ  = 3'd3;
    localparam ramOp_t OP_ASYNC_WRITE = 3'd4;

    // Encodings for the async controller itself, kept here so both blocks share one source.
    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_CONFIG,
        CTRL_READ,
        CTRL_WRITE,
        CTRL_RECOVER
    } ctrlState_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_BUSY,
        ARB_WAIT_DONE,
        ARB_RESP
    } arbState_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } portReq_t;

    function automatic ramOp_t opFor(input logic we);
        return we ? OP_ASYNC_WRITE : OP_ASYNC_READ;
    endfunction

endpackage

// File: rtl/cram_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on a tie the port not served last wins.
module cram_rr_pick (
    input  logic [1:0] iReq,
    input  logic       iLast,
    output logic [1:0] oGrant
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        oGrant = 2'b00;
        case (iReq)
            2'b01:   oGrant = 2'b01;
            2'b10:   oGrant = 2'b10;
            2'b11:   oGrant = iLast ? 2'b01 : 2'b10;
            default: oGrant = 2'b00;
        endcase
    end

endmodule

// File: rtl/cram_port_arbiter.sv
// Arbitrates two masters onto the CellularRAM async controller: one op per grant, tracks the
// Ready handshake (with timeout) and returns read data plus a one-cycle ack to the winner.
module cram_port_arbiter
    import cram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic              iWe0,
    input  logic              iWe1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iData0,
    input  logic [DATA_W-1:0] iData1,
    output logic              oAck0,
    output logic              oAck1,
    output logic              oErr0,
    output logic              oErr1,
    output logic [DATA_W-1:0] oData0,
    output logic [DATA_W-1:0] oData1,
    output logic [2:0]        oOP,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    input  logic              iReady,
    input  logic [DATA_W-1:0] iRamData,
    output logic              oBusy
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    arbState_t          state;
    arbState_t          stateNext;
    logic               lastServed;
    logic               winner;
    logic               opWe;
    logic               timedOut;
    logic               abortNow;
    logic               timerExpired;
    logic               readDone;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         grant;
    portReq_t           req0;
    portReq_t           req1;
    portReq_t           picked;

    cram_rr_pick uPick (
        .iReq   ({iReq1, iReq0}),
        .iLast  (lastServed),
        .oGrant (grant)
    );

    assign req0   = '{we: iWe0, addr: iAddr0, data: iData0};
    assign req1   = '{we: iWe1, addr: iAddr1, data: iData1};
    assign picked = grant[1] ? req1 : req0;

    // The timer holds the number of wait cycles already completed, so this is the last one allowed.
    assign timerExpired = (timer >= TIMER_W'(TIMEOUT_CYCLES - 1));
    assign readDone     = (state == ARB_WAIT_DONE) && iReady && !opWe;

    always_comb begin
        stateNext = state;
        abortNow  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (iReady && (grant != 2'b00)) stateNext = ARB_ISSUE;
            end
            ARB_ISSUE: stateNext = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: begin
                if (timerExpired) begin
                    stateNext = ARB_RESP;
                    abortNow  = 1'b1;
                end else if (!iReady) begin
                    stateNext = ARB_WAIT_DONE;
                end
            end
            ARB_WAIT_DONE: begin
                // A completion seen on the final allowed cycle still counts as success.
                if (iReady) begin
                    stateNext = ARB_RESP;
                end else if (timerExpired) begin
                    stateNext = ARB_RESP;
                    abortNow  = 1'b1;
                end
            end
            ARB_RESP: stateNext = ARB_IDLE;
            default:  stateNext = ARB_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= ARB_IDLE;
            lastServed <= 1'b1;
            winner     <= 1'b0;
            opWe       <= 1'b0;
            oAddr      <= '0;
            oData      <= '0;
            timer      <= '0;
            timedOut   <= 1'b0;
            oData0     <= '0;
            oData1     <= '0;
        end else begin
            state <= stateNext;
            case (state)
                ARB_IDLE: begin
                    if (stateNext == ARB_ISSUE) begin
                        winner     <= grant[1];
                        lastServed <= grant[1];
                        opWe       <= picked.we;
                        oAddr      <= picked.addr;
                        oData      <= picked.data;
                    end
                end
                ARB_ISSUE: timer <= '0;
                ARB_WAIT_BUSY, ARB_WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (abortNow) timedOut <= 1'b1;
                    if (readDone) begin
                        if (winner) oData1 <= iRamData;
                        else        oData0 <= iRamData;
                    end
                end
                ARB_RESP: timedOut <= 1'b0;
                default: ;
            endcase
        end
    end

    assign oOP   = (state == ARB_ISSUE) ? opFor(opWe) : OP_NULL;
    assign oAck0 = (state == ARB_RESP) && !winner;
    assign oAck1 = (state == ARB_RESP) && winner;
    assign oErr0 = oAck0 && timedOut;
    assign oErr1 = oAck1 && timedOut;
    assign oBusy = (state != ARB_IDLE);

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Scoreboard bench for cram_port_arbiter with a behavioural controller that drops Ready
// one cycle into the op and holds it low for six cycles (or forever when hung).
module tb_cram_port_arbiter;
    import cram_pkg::*;

    localparam int TIMEOUT_CYCLES = 64;

    logic              iClock = 1'b0;
    logic              iReset = 1'b1;
    logic              iReq0 = 1'b0, iReq1 = 1'b0;
    logic              iWe0 = 1'b0, iWe1 = 1'b0;
    logic [ADDR_W-1:0] iAddr0 = '0, iAddr1 = '0;
    logic [DATA_W-1:0] iData0 = '0, iData1 = '0;
    logic              oAck0, oAck1, oErr0, oErr1;
    logic [DATA_W-1:0] oData0, oData1;
    logic [2:0]        oOP;
    logic [ADDR_W-1:0] oAddr;
    logic [DATA_W-1:0] oData;
    logic              iReady = 1'b1;
    logic [DATA_W-1:0] iRamData = '0;
    logic              oBusy;

    cram_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .iClock   (iClock),
        .iReset   (iReset),
        .iReq0    (iReq0),
        .iReq1    (iReq1),
        .iWe0     (iWe0),
        .iWe1     (iWe1),
        .iAddr0   (iAddr0),
        .iAddr1   (iAddr1),
        .iData0   (iData0),
        .iData1   (iData1),
        .oAck0    (oAck0),
        .oAck1    (oAck1),
        .oErr0    (oErr0),
        .oErr1    (oErr1),
        .oData0   (oData0),
        .oData1   (oData1),
        .oOP      (oOP),
        .oAddr    (oAddr),
        .oData    (oData),
        .iReady   (iReady),
        .iRamData (iRamData),
        .oBusy    (oBusy)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        int          port;
        logic [15:0] data;
        logic        err;
    } expAck_t;

    expAck_t     expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] heldData [2] = '{16'h0, 16'h0};

    always @(posedge iClock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ramWord(input logic [22:0] a);
        if (a == 23'h001234) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Controller model: reacts to a visible op by dropping Ready, raises it after lowLeft cycles.
    bit modelEn = 1'b0;
    bit readyOverride = 1'b1;
    bit hang = 1'b0;
    int lowLeft = 0;

    always @(posedge iClock) begin
        #1;
        iRamData = ramWord(oAddr);
        if (!modelEn) begin
            iReady  = readyOverride;
            lowLeft = 0;
        end else if (lowLeft > 0) begin
            if (!hang) lowLeft--;
            if (lowLeft == 0) iReady = 1'b1;
        end else if (oOP != OP_NULL) begin
            iReady  = 1'b0;
            lowLeft = 6;
        end
    end

    // Ack monitor: every ack pops the oldest expectation.
    expAck_t mExp;
    int      mPort;
    always @(negedge iClock) begin
        if (!iReset && (oAck0 || oAck1)) begin
            mPort = oAck1 ? 1 : 0;
            check("ack_onehot", {31'b0, oAck0 & oAck1}, 32'd0);
            check("ack_expected", {31'b0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) begin
                mExp = expQ.pop_front();
                check("ack_port", mPort, mExp.port);
                check("ack_data", mPort ? oData1 : oData0, mExp.data);
                check("ack_err", mPort ? oErr1 : oErr0, mExp.err);
            end
        end
        if (!iReset && ((oErr0 && !oAck0) || (oErr1 && !oAck1)))
            check("err_without_ack", {oErr1, oErr0}, {oErr1 & oAck1, oErr0 & oAck0});
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic pushExp(input int port, input bit we, input logic [22:0] addr, input bit err);
        expAck_t e;
        if (!we && !err) heldData[port] = ramWord(addr);
        e.port = port;
        e.data = heldData[port];
        e.err  = err;
        expQ.push_back(e);
    endtask

    task automatic waitIssue(input bit we, input logic [22:0] addr, input logic [15:0] data,
                             output int issueCyc);
        int n = 0;
        @(negedge iClock);
        while (oOP == OP_NULL && n < 200) begin
            @(negedge iClock);
            n++;
        end
        issueCyc = cyc;
        check("issue_op", oOP, we ? OP_ASYNC_WRITE : OP_ASYNC_READ);
        check("issue_addr", oAddr, addr);
        if (we) check("issue_wdata", oData, data);
    endtask

    task automatic waitAck(input int port, output int ackCyc);
        int          n = 0;
        bit          stable = 1'b1;
        logic [22:0] a;
        logic [15:0] d;
        a = oAddr;
        d = oData;
        @(negedge iClock);
        check("op_one_cycle", oOP, OP_NULL);
        while (!(port ? oAck1 : oAck0) && n < 300) begin
            if (oAddr !== a || oData !== d) stable = 1'b0;
            @(negedge iClock);
            n++;
        end
        if (oAddr !== a || oData !== d) stable = 1'b0;
        ackCyc = cyc;
        check("ack_seen", port ? oAck1 : oAck0, 1);
        check("addr_data_hold", stable, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int  issue, ack;
        bit  stalled;
        logic [22:0] cAddr [2];

        waitCycles(3);
        check("rst_op", oOP, OP_NULL);
        check("rst_addr", oAddr, 0);
        check("rst_wdata", oData, 0);
        check("rst_ack_err", {oAck1, oAck0, oErr1, oErr0}, 0);
        check("rst_rdata", {oData1, oData0}, 0);
        check("rst_busy", oBusy, 0);
        modelEn = 1'b1;
        iReset  = 1'b0;
        waitCycles(1);

        // Single read on port 0
        iAddr0 = 23'h001234; iWe0 = 1'b0; iReq0 = 1'b1;
        pushExp(0, 1'b0, iAddr0, 1'b0);
        waitIssue(1'b0, 23'h001234, 16'h0, issue);
        waitAck(0, ack);
        iReq0 = 1'b0;
        check("read_latency", ack - issue, 7);
        check("read_data0", oData0, 16'hBEEF);
        waitCycles(2);

        // Single write on port 1 at the top address
        iAddr1 = 23'h7FFFFF; iData1 = 16'hA5A5; iWe1 = 1'b1; iReq1 = 1'b1;
        pushExp(1, 1'b1, iAddr1, 1'b0);
        waitIssue(1'b1, 23'h7FFFFF, 16'hA5A5, issue);
        waitAck(1, ack);
        iReq1 = 1'b0; iWe1 = 1'b0;
        check("write_keeps_rdata1", oData1, 16'h0);
        waitCycles(2);

        // Contention: both held for four transactions, grants must alternate 0,1,0,1
        cAddr[0] = 23'h000100; cAddr[1] = 23'h2A0055;
        iAddr0 = cAddr[0]; iAddr1 = cAddr[1];
        for (int i = 0; i < 4; i++) pushExp(i % 2, 1'b0, cAddr[i % 2], 1'b0);
        iReq0 = 1'b1; iReq1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitIssue(1'b0, cAddr[i % 2], 16'h0, issue);
            waitAck(i % 2, ack);
        end
        iReq0 = 1'b0; iReq1 = 1'b0;
        waitCycles(2);

        // Timeout: controller never completes; ISSUE plus TIMEOUT_CYCLES wait cycles, then RESP
        hang = 1'b1;
        iAddr0 = 23'h000777; iReq0 = 1'b1;
        pushExp(0, 1'b0, iAddr0, 1'b1);
        waitIssue(1'b0, 23'h000777, 16'h0, issue);
        waitAck(0, ack);
        iReq0 = 1'b0;
        hang  = 1'b0;
        check("timeout_latency", ack - issue, TIMEOUT_CYCLES + 1);
        check("timeout_keeps_rdata0", oData0, ramWord(23'h000100));
        waitCycles(2);

        // Next request after a timeout is served normally
        iAddr0 = 23'h000042; iReq0 = 1'b1;
        pushExp(0, 1'b0, iAddr0, 1'b0);
        waitIssue(1'b0, 23'h000042, 16'h0, issue);
        waitAck(0, ack);
        iReq0 = 1'b0;
        waitCycles(2);

        // Ready low in IDLE holds the request off
        modelEn = 1'b0; readyOverride = 1'b0;
        waitCycles(2);
        iAddr0 = 23'h003333; iReq0 = 1'b1;
        pushExp(0, 1'b0, iAddr0, 1'b0);
        stalled = 1'b1;
        repeat (5) begin
            @(negedge iClock);
            if (oOP != OP_NULL || oBusy) stalled = 1'b0;
        end
        check("no_issue_while_not_ready", stalled, 1);
        readyOverride = 1'b1;
        @(negedge iClock);
        modelEn = 1'b1;
        check("no_issue_before_ready_sampled", oOP, OP_NULL);
        @(negedge iClock);
        issue = cyc;
        check("issue_after_ready", oOP, OP_ASYNC_READ);
        check("issue_after_ready_addr", oAddr, 23'h003333);
        waitAck(0, ack);
        iReq0 = 1'b0;
        waitCycles(2);

        // Reset during WAIT_DONE: aborted with no ack, port 0 wins first after release
        iAddr0 = 23'h004444; iAddr1 = 23'h005555;
        iReq0 = 1'b1; iReq1 = 1'b1;
        waitIssue(1'b0, 23'h005555, 16'h0, issue);
        waitCycles(2);
        iReset = 1'b1;
        @(negedge iClock);
        check("midrst_op", oOP, OP_NULL);
        check("midrst_busy", oBusy, 0);
        check("midrst_ack", {oAck1, oAck0}, 0);
        check("midrst_rdata", {oData1, oData0}, 0);
        heldData[0] = 16'h0; heldData[1] = 16'h0;
        iReset = 1'b0;
        pushExp(0, 1'b0, iAddr0, 1'b0);
        pushExp(1, 1'b0, iAddr1, 1'b0);
        waitIssue(1'b0, 23'h004444, 16'h0, issue);
        waitAck(0, ack);
        iReq0 = 1'b0;
        waitIssue(1'b0, 23'h005555, 16'h0, issue);
        waitAck(1, ack);
        iReq1 = 1'b0;

        waitCycles(3);
        check("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cram_port_arbiter.md
Name: cram_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the CellularRAM async controller.
- Round-robin grants. Drives one controller op (OP_ASYNC_READ or OP_ASYNC_WRITE) per grant.
- Tracks the controller Ready handshake to completion, returns read data plus a one-cycle ack to the winning requester.
- Sits between the CPU/video masters and the RAM controller; the only block allowed to drive the controller op/addr/data inputs.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT_BUSY+WAIT_DONE before abort with error.
- OP_NULL, 3'd0: controller op code, no operation.
- OP_ASYNC_READ, 3'd3: controller op code, async read.
- OP_ASYNC_WRITE, 3'd4: controller op code, async write.

Ports:
- iClock  in  1  system clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iReq0 / iReq1  in  1  request level; held until matching ack
- iWe0 / iWe1  in  1  1=write, 0=read; sampled with grant
- iAddr0 / iAddr1  in  23  word address
- iData0 / iData1  in  16  write data
- oAck0 / oAck1  out  1  one-cycle completion pulse
- oErr0 / oErr1  out  1  one-cycle timeout flag, coincident with ack
- oData0 / oData1  out  16  read data, valid in ack cycle, held until next ack to that port
- oOP  out  3  op to controller
- oAddr  out  23  address to controller
- oData  out  16  write data to controller
- iReady  in  1  controller ready (accepts ops when high)
- iRamData  in  16  read data from RAM capture path
- oBusy  out  1  high in any state except IDLE

Behaviour:
- Reset (sync): state=IDLE, oOP=OP_NULL, oAddr=0, oData=0, oAck*=0, oErr*=0, oData0/1=0, timer=0, last-served pointer=1 (port0 wins first tie).
- Reset mid-operation aborts with no ack. The requester keeps iReq high and is re-served after reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If iReady=1 and any iReq=1, pick the winner and latch its we/addr/data into oAddr/oData and an internal op reg; go ISSUE.
  - If iReady=0, requests wait.
- Winner selection: only one requester -> it wins. Both requesting -> the port not served last wins. Pointer updates on grant.
- ISSUE: oOP=OP_ASYNC_WRITE if we else OP_ASYNC_READ for exactly this one cycle; go WAIT_BUSY. oOP=OP_NULL in every other state.
- WAIT_BUSY: wait for iReady=0, then go WAIT_DONE.
- WAIT_DONE: wait for iReady=1.
  - For reads, capture iRamData into the winner's oData reg on that edge.
  - For writes, leave oData reg unchanged.
  - Go RESP.
- Timer: cleared on ISSUE, increments in WAIT_BUSY and WAIT_DONE. If it reaches TIMEOUT_CYCLES, go RESP with an error flag set and do not update read data.
- RESP:
  - Assert winner's oAck for one cycle; assert oErr too if the timeout flag is set. Clear the flag; go IDLE.
  - Requests are ignored in RESP, so the requester has one cycle to drop iReq. A request still high in the following IDLE cycle is a new request.
- oAddr/oData hold stable from ISSUE through RESP. The controller relies on this for the write data and address hold window.
- Nominal read latency with the controller: IDLE->RESP = 1 + 1 + (controller busy cycles + 1) + 1.
- Requests changing we/addr/data while pending but not granted: the value at the grant edge is used.
- Starvation bound: a pending port is served within one other transaction.

Decomposition:
- Shared package cram_pkg: controller op-code constants (OP_*), address width 23, data width 16, controller state encodings. The RAM controller will later migrate to the same package.
- One natural sub-module: cram_rr_pick (2-way round-robin picker: reqs + last pointer -> grant one-hot). The FSM, timer and latches stay in the top.

Test Plan:
- Controller model drops iReady 1 cycle after op, holds low 6 cycles:
  - Single read: iReq0, addr 0x00_1234, iRamData=0xBEEF -> oOP=3 for exactly 1 cycle, oAck0 one pulse, oData0=0xBEEF, oErr0=0.
  - Single write: iReq1, iWe1=1, addr 0x7F_FFFF, data 0xA5A5 -> oOP=4 one cycle; oAddr=0x7FFFFF and oData=0xA5A5 stable through RESP; oAck1 pulse; oData1 unchanged.
  - Contention: iReq0 and iReq1 high together from reset, held after each ack -> grants alternate 0,1,0,1 over 4 transactions.
  - Timeout: model keeps iReady=0 after op; TIMEOUT_CYCLES=64 -> oAck0 and oErr0 together 64 cycles after ISSUE; oData0 unchanged; next request served normally.
  - iReady=0 in IDLE with iReq0 high -> no ISSUE until iReady=1, then oOP pulses the following cycle.
  - Reset asserted during WAIT_DONE -> next cycle oOP=0, oBusy=0, no ack. iReq0 held -> re-served after reset release, port0 first.
